// File: rtl/rst_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL reset/lock sequencer.
package rst_ctrl_pkg;

  localparam int LOSS_CNT_W  = 8;
  localparam int RETRY_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } rst_state_t;

  // Counter only ever holds (param - 1), so clog2 of the largest parameter suffices.
  function automatic int ctr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic 2-flop synchronizer; output and stages clear to 0 on reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [1:0][W-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset pulse, lock wait with timeout/retry, and stable-lock gated system reset.
// Define PLL_RST_CTRL_STATS_EN to export retry_cnt and loss_cnt.
module pll_rst_ctrl
  import rst_ctrl_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RETRY_MAX      = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   soft_rst,
  output logic                   pll_rst,
  output logic                   sys_rst,
  output logic                   ready,
`ifdef PLL_RST_CTRL_STATS_EN
  output logic [RETRY_CNT_W-1:0] retry_cnt,
  output logic [LOSS_CNT_W-1:0]  loss_cnt,
`endif
  output logic                   fault
);

  localparam int CW = ctr_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] RST_LD = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LD = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LD = CW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_CNT_W-1:0] RETRY_LIM = RETRY_CNT_W'(RETRY_MAX);

  logic                   lk;
  rst_state_t             st, st_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [RETRY_CNT_W-1:0] retry_q, retry_nxt;

  sync2 #(.W(1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk)
  );

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    retry_nxt = retry_q;
    if (soft_rst) begin
      st_nxt    = ST_PLL_RST;
      cnt_nxt   = RST_LD;
      retry_nxt = '0;
    end else begin
      case (st)
        ST_PLL_RST: begin
          if (cnt == '0) begin
            st_nxt  = ST_WAIT_LOCK;
            cnt_nxt = TMO_LD;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked before expiry so a last-cycle lock still counts.
          if (lk) begin
            st_nxt  = ST_STABLE;
            cnt_nxt = STB_LD;
          end else if (cnt == '0) begin
            retry_nxt = retry_q + RETRY_CNT_W'(1);
            if (retry_nxt == RETRY_LIM) begin
              st_nxt  = ST_FAULT;
              cnt_nxt = '0;
            end else begin
              st_nxt  = ST_PLL_RST;
              cnt_nxt = RST_LD;
            end
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        ST_STABLE: begin
          if (!lk) begin
            st_nxt  = ST_WAIT_LOCK;
            cnt_nxt = TMO_LD;
          end else if (cnt == '0) begin
            st_nxt  = ST_RUN;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        ST_RUN: begin
          if (!lk) begin
            st_nxt  = ST_PLL_RST;
            cnt_nxt = RST_LD;
          end
        end
        ST_FAULT: begin
          st_nxt = ST_FAULT;
        end
        default: begin
          st_nxt  = ST_PLL_RST;
          cnt_nxt = RST_LD;
        end
      endcase
    end
  end

  // Outputs decoded from next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= ST_PLL_RST;
      cnt     <= RST_LD;
      retry_q <= '0;
      pll_rst <= 1'b1;
      sys_rst <= 1'b1;
      ready   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= cnt_nxt;
      retry_q <= retry_nxt;
      pll_rst <= (st_nxt == ST_PLL_RST) || (st_nxt == ST_FAULT);
      sys_rst <= (st_nxt != ST_RUN);
      ready   <= (st_nxt == ST_RUN);
      fault   <= (st_nxt == ST_FAULT);
    end
  end

`ifdef PLL_RST_CTRL_STATS_EN
  logic [LOSS_CNT_W-1:0] loss_q;

  always_ff @(posedge clk) begin
    if (rst)
      loss_q <= '0;
    else if (!soft_rst && st == ST_RUN && !lk && loss_q != '1)
      loss_q <= loss_q + LOSS_CNT_W'(1);
  end

  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;
`endif

endmodule

// File: doc/pll_rst_ctrl.md
# pll_rst_ctrl

Reset and lock sequencer for the on-chip PLL. Runs on the free-running reference clock, pulses the PLL reset, waits for lock with a timeout and retry limit, and holds the design's system reset until lock has been stable for a programmable interval. Sits between the reference-clock input buffer and the PLL instance in the top level; its `sys_rst` output replaces direct gating of logic on the raw `locked` signal.

## Interface
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: cycles allowed in WAIT_LOCK before a retry (≥1).
- `STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `RETRY_MAX`, 7: failed attempts tolerated before FAULT (1..15).
- `clk`  input  1  reference clock, free-running, never gated by this block.
- `rst`  input  1  synchronous, active-high reset.
- `pll_locked`  input  1  PLL lock, asynchronous to `clk`.
- `soft_rst`  input  1  single-cycle request to rerun the full sequence.
- `pll_rst`  output  1  PLL reset, active-high.
- `sys_rst`  output  1  system reset, active-high, synchronous to `clk`.
- `ready`  output  1  high only in RUN.
- `fault`  output  1  high only in FAULT.
- `retry_cnt`  output  4  failed attempts since last `rst`/`soft_rst` (stats build only).
- `loss_cnt`  output  8  lock losses seen in RUN, saturating (stats build only).

## Operation
- `pll_locked` passes through a 2-flop synchronizer; all logic below uses the synchronized `lk`.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT. A single down-counter, reloaded on every state entry, serves all timed states.
- PLL_RST: `pll_rst`=1, `sys_rst`=1. After `PLL_RST_CYCLES` cycles -> WAIT_LOCK.
- WAIT_LOCK: `pll_rst`=0, `sys_rst`=1. `lk`=1 -> STABLE. Counter expiry without lock -> retry counter +1; if the new value equals `RETRY_MAX` -> FAULT, else -> PLL_RST.
- STABLE: `lk`=0 -> WAIT_LOCK, timeout counter reloaded, no retry charged. `STABLE_CYCLES` consecutive cycles with `lk`=1 -> RUN.
- RUN: `sys_rst`=0, `ready`=1. `lk`=0 -> PLL_RST and `sys_rst`=1 in the same transition; `loss_cnt` +1, saturating at 255.
- FAULT: `pll_rst`=1, `sys_rst`=1, `fault`=1. Sticky; exited only by `rst` or `soft_rst`.
- `soft_rst` in any state -> PLL_RST, counter reloaded, retry counter cleared, `loss_cnt` kept. It takes priority over all other transitions in that cycle.
- Outputs `pll_rst`, `sys_rst`, `ready`, and `fault` are registered and decoded from the next state, so there are no glitches.

## Timing
- `rst`=1: state PLL_RST, counter = `PLL_RST_CYCLES`-1. `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0, both stat counters 0, synchronizer flops 0.
- Reset is synchronous. Asserting `rst` mid-sequence or in RUN takes effect on the next edge.
- Lock detection latency is 2 synchronizer cycles plus 1 FSM cycle.
- Minimum `sys_rst` deassertion delay with instant lock: `PLL_RST_CYCLES` + 3 + `STABLE_CYCLES` cycles after `rst` falls.
- Lock loss in RUN: `sys_rst` rises 3 cycles after `pll_locked` falls.
- A `lk` glitch in STABLE restarts the full stable count.
- If lock arrives on the same cycle as WAIT_LOCK expiry, lock wins and the next state is STABLE.
- The counter is sized to `$clog2` of the largest parameter and never wraps.

## Configuration
- `PLL_RST_CTRL_STATS_EN` defined: `retry_cnt` and `loss_cnt` ports and registers are present.
- Not defined: both ports are absent. The internal retry counter is kept because it is needed for FAULT, but it is not exported. `loss_cnt` logic is removed.

## Structure
- Shared package `rst_ctrl_pkg` holds:
  - the state enum `rst_state_t`;
  - counter-width function;
  - `LOSS_CNT_W`=8 and `RETRY_CNT_W`=4.
- Sub-module `sync2`: a generic 2-flop synchronizer marked ASYNC_REG, with its output reset to 0. It is reused by other clock-crossing blocks.

## Test plan
Benches use small parameters: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `RETRY_MAX`=3.
- Lock asserted 2 cycles after `pll_rst` falls, held high -> `sys_rst` falls exactly 4+2+3+8 cycles after `rst` release; `ready`=1.
- `pll_locked` never asserted -> three PLL_RST pulses of 4 cycles each, then `fault`=1, `pll_rst`=1, `retry_cnt`=3. A later `soft_rst` pulse -> PLL_RST, `retry_cnt`=0.
- Lock drops for 1 cycle midway through STABLE -> stable count restarts; no retry charged; release is delayed by the elapsed count.
- In RUN, `pll_locked` falls -> `sys_rst`=1 after 3 cycles, `loss_cnt`=1, sequence reruns and returns to RUN. Forcing 300 losses -> `loss_cnt` holds at 255.
- `rst` asserted while in RUN and while in WAIT_LOCK -> all outputs at their reset values on the next edge.
- Lock arriving on the WAIT_LOCK expiry cycle -> STABLE entered, `retry_cnt` unchanged.
